game_flow_controller: RTL and testbench

Top-level game sequencer for the Frogger design. Owns the level (1..MAX_LEVEL) and lives registers and runs the play / pause / game-over state machine. Issues frog-reset pulses and a `game_active` freeze to the frog, car and display blocks. Sits between the debounced switch inputs and the frog/collision logic; `level` feeds the two-digit 7-segment display path.

---
 rtl/game_flow_controller_pkg.sv | 17 +
 rtl/game_flow_controller_rise_detect.sv | 18 +
 rtl/game_flow_controller.sv | 109 ++++++++++
 tb/tb_game_flow_controller.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/game_flow_controller_pkg.sv
// Shared game-flow definitions: state encodings and default game limits.
package game_flow_controller_pkg;

  localparam logic [1:0] ST_PLAY        = 2'd0;
  localparam logic [1:0] ST_HIT_PAUSE   = 2'd1;
  localparam logic [1:0] ST_LEVEL_PAUSE = 2'd2;
  localparam logic [1:0] ST_OVER        = 2'd3;

  localparam int unsigned DEF_START_LIVES = 3;
  localparam int unsigned DEF_MAX_LEVEL   = 15;

  // A pause of one cycle still needs a one-bit timer register.
  function automatic int unsigned timer_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/game_flow_controller_rise_detect.sv
// Rising-edge strobe of a level input against its previous-cycle sample.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b0;
    else       prev <= in;
  end

  assign rise = in & ~prev;

endmodule

// File: rtl/game_flow_controller.sv
// Frogger game sequencer: level/lives bookkeeping and play/pause/over FSM.
module game_flow_controller
  import game_flow_controller_pkg::*;
#(
  parameter int unsigned MAX_LEVEL    = DEF_MAX_LEVEL,
  parameter int unsigned START_LIVES  = DEF_START_LIVES,
  parameter int unsigned PAUSE_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       debounced_sw1,
  input  logic       debounced_sw2,
  input  logic       debounced_sw3,
  input  logic       debounced_sw4,
  input  logic       frog_at_top,
  input  logic       collision,
  output logic [3:0] level,
  output logic [1:0] lives,
  output logic       reset_frog,
  output logic       game_active,
  output logic       game_over,
  output logic       level_up
);

  localparam int unsigned TW = timer_width(PAUSE_CYCLES);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(PAUSE_CYCLES - 1);

  logic restart_rise, hit_rise, goal_rise;
  logic all_sw;

  assign all_sw = debounced_sw1 & debounced_sw2 & debounced_sw3 & debounced_sw4;

  rise_detect u_restart (.clk(clk), .reset(reset), .in(all_sw),      .rise(restart_rise));
  rise_detect u_hit     (.clk(clk), .reset(reset), .in(collision),   .rise(hit_rise));
  rise_detect u_goal    (.clk(clk), .reset(reset), .in(frog_at_top), .rise(goal_rise));

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    level_d;
  logic [1:0]    lives_d;
  logic          reset_frog_d, level_up_d;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    level_d      = level;
    lives_d      = lives;
    reset_frog_d = 1'b0;
    level_up_d   = 1'b0;
    if (restart_rise) begin
      state_d      = ST_PLAY;
      timer_d      = '0;
      level_d      = 4'd1;
      lives_d      = 2'(START_LIVES);
      reset_frog_d = 1'b1;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (hit_rise) begin
            reset_frog_d = 1'b1;
            if (lives > 2'd1) begin
              lives_d = lives - 2'd1;
              timer_d = TIMER_LOAD;
              state_d = ST_HIT_PAUSE;
            end else begin
              lives_d = '0;
              state_d = ST_OVER;
            end
          end else if (goal_rise) begin
            if (level < 4'(MAX_LEVEL)) level_d = level + 4'd1;
            level_up_d   = 1'b1;
            reset_frog_d = 1'b1;
            timer_d      = TIMER_LOAD;
            state_d      = ST_LEVEL_PAUSE;
          end
        end
        ST_HIT_PAUSE, ST_LEVEL_PAUSE: begin
          if (timer_q == '0) state_d = ST_PLAY;
          else               timer_d = timer_q - TW'(1);
        end
        default: ;
      endcase
    end
  end

  // Status flags are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_PLAY;
      timer_q     <= '0;
      level       <= 4'd1;
      lives       <= 2'(START_LIVES);
      reset_frog  <= 1'b0;
      level_up    <= 1'b0;
      game_active <= 1'b1;
      game_over   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      level       <= level_d;
      lives       <= lives_d;
      reset_frog  <= reset_frog_d;
      level_up    <= level_up_d;
      game_active <= (state_d == ST_PLAY);
      game_over   <= (state_d == ST_OVER);
    end
  end

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed vector bench for game_flow_controller with a 4-cycle pause.
module tb_game_flow_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw;
  logic       frog_at_top, collision;
  logic [3:0] level;
  logic [1:0] lives;
  logic       reset_frog, game_active, game_over, level_up;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  game_flow_controller #(
    .MAX_LEVEL(15),
    .START_LIVES(3),
    .PAUSE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .debounced_sw1(sw[0]),
    .debounced_sw2(sw[1]),
    .debounced_sw3(sw[2]),
    .debounced_sw4(sw[3]),
    .frog_at_top(frog_at_top),
    .collision(collision),
    .level(level),
    .lives(lives),
    .reset_frog(reset_frog),
    .game_active(game_active),
    .game_over(game_over),
    .level_up(level_up)
  );

  typedef struct {
    logic [3:0] sw;
    logic       col;
    logic       top;
    logic [3:0] lv;
    logic [1:0] li;
    logic       rf;
    logic       ga;
    logic       go;
    logic       lu;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] s, input logic c, input logic t,
                              input logic [3:0] lv, input logic [1:0] li,
                              input logic rf, input logic ga, input logic go, input logic lu);
    vec_t v;
    v.sw = s; v.col = c; v.top = t;
    v.lv = lv; v.li = li; v.rf = rf; v.ga = ga; v.go = go; v.lu = lu;
    return v;
  endfunction

  task automatic check_outs(input string name, input logic [3:0] lv, input logic [1:0] li,
                            input logic rf, input logic ga, input logic go, input logic lu);
    logic [9:0] act, exp;
    act = {level, lives, reset_frog, game_active, game_over, level_up};
    exp = {lv, li, rf, ga, go, lu};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got lv=%0d li=%0d rf=%b ga=%b go=%b lu=%b, want lv=%0d li=%0d rf=%b ga=%b go=%b lu=%b",
               name, level, lives, reset_frog, game_active, game_over, level_up,
               lv, li, rf, ga, go, lu);
    end
  endtask

  task automatic step(input logic [3:0] s, input logic c, input logic t);
    @(negedge clk);
    sw = s; collision = c; frog_at_top = t;
    @(posedge clk);
    #1;
  endtask

  task automatic push_rep(input int n, input vec_t v);
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b1; sw = '0; frog_at_top = 1'b0; collision = 1'b0;

    // Three hits: 3 -> 2 -> 1 -> over, 4-cycle freeze after the first two.
    vecs.push_back(mk(4'h0, 1, 0, 1, 2, 1, 0, 0, 0));
    push_rep(3,    mk(4'h0, 0, 0, 1, 2, 0, 0, 0, 0));
    vecs.push_back(mk(4'h0, 0, 0, 1, 2, 0, 1, 0, 0));
    vecs.push_back(mk(4'h0, 1, 0, 1, 1, 1, 0, 0, 0));
    push_rep(3,    mk(4'h0, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(4'h0, 0, 0, 1, 1, 0, 1, 0, 0));
    vecs.push_back(mk(4'h0, 1, 0, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(4'h0, 0, 0, 1, 0, 0, 0, 1, 0));
    // OVER ignores hits and goals.
    vecs.push_back(mk(4'h0, 1, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(4'h0, 0, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(4'h0, 0, 1, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(4'h0, 0, 0, 1, 0, 0, 0, 1, 0));
    // Restart from OVER; held switches do not repeat.
    vecs.push_back(mk(4'hF, 0, 0, 1, 3, 1, 1, 0, 0));
    vecs.push_back(mk(4'hF, 0, 0, 1, 3, 0, 1, 0, 0));
    vecs.push_back(mk(4'h0, 0, 0, 1, 3, 0, 1, 0, 0));
    // Goal with frog_at_top held through and past the pause.
    vecs.push_back(mk(4'h0, 0, 1, 2, 3, 1, 0, 0, 1));
    push_rep(3,    mk(4'h0, 0, 1, 2, 3, 0, 0, 0, 0));
    push_rep(2,    mk(4'h0, 0, 1, 2, 3, 0, 1, 0, 0));
    vecs.push_back(mk(4'h0, 0, 0, 2, 3, 0, 1, 0, 0));
    // Restart in the middle of a hit pause.
    vecs.push_back(mk(4'h0, 1, 0, 2, 2, 1, 0, 0, 0));
    vecs.push_back(mk(4'h0, 0, 0, 2, 2, 0, 0, 0, 0));
    vecs.push_back(mk(4'hF, 0, 0, 1, 3, 1, 1, 0, 0));
    vecs.push_back(mk(4'hF, 0, 0, 1, 3, 0, 1, 0, 0));
    vecs.push_back(mk(4'h0, 0, 0, 1, 3, 0, 1, 0, 0));
    // Simultaneous hit and goal at lives=2: hit wins, goal dropped.
    vecs.push_back(mk(4'h0, 1, 0, 1, 2, 1, 0, 0, 0));
    push_rep(3,    mk(4'h0, 0, 0, 1, 2, 0, 0, 0, 0));
    vecs.push_back(mk(4'h0, 0, 0, 1, 2, 0, 1, 0, 0));
    vecs.push_back(mk(4'h0, 1, 1, 1, 1, 1, 0, 0, 0));
    push_rep(3,    mk(4'h0, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(4'h0, 0, 0, 1, 1, 0, 1, 0, 0));

    repeat (3) @(posedge clk);
    #1;
    check_outs("reset_values", 4'd1, 2'd3, 0, 1, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].sw, vecs[i].col, vecs[i].top);
      check_outs($sformatf("vec%0d", i), vecs[i].lv, vecs[i].li,
                 vecs[i].rf, vecs[i].ga, vecs[i].go, vecs[i].lu);
    end

    // Level saturation: 16 goals from level 1 stop at 15, level_up still pulses.
    for (int g = 1; g <= 16; g++) begin
      automatic logic [3:0] exp_lv = (g + 1 > 15) ? 4'd15 : 4'(g + 1);
      step(4'h0, 0, 1);
      check_outs($sformatf("goal%0d", g), exp_lv, 2'd1, 1, 0, 0, 1);
      repeat (3) step(4'h0, 0, 0);
      step(4'h0, 0, 0);
      check_outs($sformatf("goal%0d_resume", g), exp_lv, 2'd1, 0, 1, 0, 0);
    end

    // Reset during a level pause: reset values next cycle, no pause resumes.
    step(4'h0, 0, 1);
    check_outs("lp_enter", 4'd15, 2'd1, 1, 0, 0, 1);
    step(4'h0, 0, 0);
    check_outs("lp_mid", 4'd15, 2'd1, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_outs("lp_reset", 4'd1, 2'd3, 0, 1, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(4'h0, 0, 0);
      check_outs($sformatf("post_reset%0d", k), 4'd1, 2'd3, 0, 1, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
